// File: rtl/rf_read_arbiter_pkg.sv
// Shared widths and helpers for the register-file read arbiter.
// The tag's valid bit sits just above the requestor index.
package rf_read_arbiter_pkg;

    localparam int NUM_BANKS_DEF = 4;
    localparam int NUM_REQ_DEF   = 8;
    localparam int ADDR_W_DEF    = 8;
    localparam int BANK_W        = 2;
    localparam int OCID_W        = 3;
    localparam int OCID_VLD      = OCID_W;

    typedef logic [OCID_W-1:0] req_idx_t;

    function automatic req_idx_t onehot_to_idx(input logic [7:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = idx | req_idx_t'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rf_read_arbiter_rr.sv
// 8-way round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; the pointer is owned by the caller.
module rr_arbiter_8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [7:0] grant,
    output logic       found
);

    logic [2:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < 8; off++) begin
            idx = ptr + 3'(off);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Operand-collector read arbiter: one round-robin grant per bank per cycle,
// registered read enable/address, then a tag aligned with bank read data.
module rf_read_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BANK_W*NUM_REQ-1:0] req_bank,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_grant,
    input  logic                      RF_WR_0,
    input  logic                      RF_WR_1,
    input  logic                      RF_WR_2,
    input  logic                      RF_WR_3,
    output logic                      rd_en_0,
    output logic                      rd_en_1,
    output logic                      rd_en_2,
    output logic                      rd_en_3,
    output logic [ADDR_W-1:0]         rd_addr_0,
    output logic [ADDR_W-1:0]         rd_addr_1,
    output logic [ADDR_W-1:0]         rd_addr_2,
    output logic [ADDR_W-1:0]         rd_addr_3,
    output logic [OCID_W:0]           ocid_0,
    output logic [OCID_W:0]           ocid_1,
    output logic [OCID_W:0]           ocid_2,
    output logic [OCID_W:0]           ocid_3
);

    logic [NUM_BANKS-1:0]              wr;
    logic [NUM_BANKS-1:0][7:0]         cand;
    logic [NUM_BANKS-1:0][7:0]         bgrant;
    logic [NUM_BANKS-1:0]              found;
    logic [NUM_BANKS-1:0][OCID_W-1:0]  ptr;
    logic [NUM_BANKS-1:0][OCID_W-1:0]  gidx;
    logic [NUM_BANKS-1:0][OCID_W-1:0]  idx_q;
    logic [NUM_BANKS-1:0][OCID_W-1:0]  tag_q;
    logic [NUM_BANKS-1:0][ADDR_W-1:0]  gaddr;
    logic [NUM_BANKS-1:0][ADDR_W-1:0]  addr_q;
    // [0] = read issued this cycle, [1] = bank data / tag valid this cycle
    logic [NUM_BANKS-1:0][1:0]         vld_pipe;
    logic [7:0]                        grant_all;

    assign wr = {RF_WR_3, RF_WR_2, RF_WR_1, RF_WR_0};

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        // Reset low or writeback on this bank removes every candidate.
        always_comb begin
            cand[k] = '0;
            for (int i = 0; i < NUM_REQ; i++)
                cand[k][i] = rst && !wr[k] && req_valid[i] &&
                             (req_bank[BANK_W*i +: BANK_W] == BANK_W'(k));
        end

        rr_arbiter_8 u_arb (
            .req   (cand[k]),
            .ptr   (ptr[k]),
            .grant (bgrant[k]),
            .found (found[k])
        );

        assign gidx[k]  = onehot_to_idx(bgrant[k]);
        assign gaddr[k] = req_addr[int'(gidx[k])*ADDR_W +: ADDR_W];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr[k]      <= '0;
                vld_pipe[k] <= '0;
                idx_q[k]    <= '0;
                tag_q[k]    <= '0;
                addr_q[k]   <= '0;
            end else begin
                vld_pipe[k] <= {vld_pipe[k][0], found[k]};
                tag_q[k]    <= vld_pipe[k][0] ? idx_q[k] : '0;
                if (found[k]) begin
                    ptr[k]    <= gidx[k] + 1'b1;
                    idx_q[k]  <= gidx[k];
                    addr_q[k] <= gaddr[k];
                end
            end
        end
    end

    always_comb begin
        grant_all = '0;
        for (int k = 0; k < NUM_BANKS; k++)
            grant_all = grant_all | bgrant[k];
    end

    assign req_grant = grant_all[NUM_REQ-1:0];

    assign rd_en_0   = vld_pipe[0][0];
    assign rd_en_1   = vld_pipe[1][0];
    assign rd_en_2   = vld_pipe[2][0];
    assign rd_en_3   = vld_pipe[3][0];
    assign rd_addr_0 = addr_q[0];
    assign rd_addr_1 = addr_q[1];
    assign rd_addr_2 = addr_q[2];
    assign rd_addr_3 = addr_q[3];
    assign ocid_0    = {vld_pipe[0][1], tag_q[0]};
    assign ocid_1    = {vld_pipe[1][1], tag_q[1]};
    assign ocid_2    = {vld_pipe[2][1], tag_q[2]};
    assign ocid_3    = {vld_pipe[3][1], tag_q[3]};

endmodule

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, per-bank register row address width.
REQ-002 Parameter NUM_BANKS, default 4, number of register-file banks.
REQ-003 Parameter NUM_REQ, default 8, number of requestors; index = {collector_unit[1:0], src_sel}.
REQ-004 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst  in  1  reset, asynchronous and active-low.
REQ-006 Port req_valid  in  NUM_REQ  per-requestor operand read request.
REQ-007 Port req_bank  in  2*NUM_REQ  target bank of each requestor, 2 bits per requestor.
REQ-008 Port req_addr  in  ADDR_W*NUM_REQ  bank row address of each requestor.
REQ-009 Port req_grant  out  NUM_REQ  one-hot-per-bank acceptance of a request, combinational, same cycle.
REQ-010 Ports RF_WR_0..RF_WR_3  in  1 each  bank busy with writeback this cycle.
REQ-011 Ports rd_en_0..rd_en_3  out  1 each  registered bank read enable.
REQ-012 Ports rd_addr_0..rd_addr_3  out  ADDR_W each  registered bank read address.
REQ-013 Ports ocid_0..ocid_3  out  4 each  tag for bank DataOut: bit 3 valid, bits 2:0 requestor index.

Function
REQ-014 Handshake: requestor holds req_valid, req_bank and req_addr stable until the cycle req_grant is high; the request is consumed in that cycle.
REQ-015 Per bank k, candidates are requestors with req_valid high and req_bank equal to k.
REQ-016 Bank k grants no requestor in any cycle RF_WR_k is high (writeback priority).
REQ-017 Otherwise bank k grants exactly one candidate per cycle by round-robin, starting search at pointer ptr_k and ascending modulo NUM_REQ.
REQ-018 ptr_k updates to (granted index + 1) mod NUM_REQ on a grant, wrapping 7 -> 0; it holds when there is no grant.
REQ-019 req_grant[i] is never high while req_valid[i] is low; at most one grant per bank per cycle; up to four grants per cycle across banks.
REQ-020 Latency: grant in cycle N -> rd_en_k=1 and rd_addr_k=granted address in cycle N+1 -> ocid_k={1,index} in cycle N+2, aligned with the one-cycle bank read data.
REQ-021 With no grant in cycle N: rd_en_k=0 in cycle N+1 and ocid_k[3]=0 in cycle N+2. rd_addr_k holds its previous value.
REQ-022 Back-to-back grants to one bank produce consecutive ocid_k tags with no bubble.
REQ-023 RF_WR_k high while a read is already in the pipeline does not cancel that read.

Reset
REQ-024 While rst is low: all rd_en_k=0, rd_addr_k=0, ocid_k=4'b0000, and all ptr_k=0.
REQ-025 Reset mid-operation discards in-flight reads; no ocid valid appears after rst rises for grants made before reset.
REQ-026 req_grant is forced to 0 while rst is low.

Structure
REQ-027 Shared package holds NUM_BANKS, NUM_REQ, ADDR_W defaults, the OCID_W=3 tag width, and the ocid valid-bit position.
REQ-028 One sub-module, rr_arbiter_8 (request vector, pointer in; one-hot grant, found flag out), is instantiated once per bank.
REQ-029 The pipeline registers and round-robin pointers reside in rf_read_arbiter.

Verification
REQ-030 Single request: req_valid=8'h01, bank 2, addr 8'h15 -> grant[0] in cycle 0; rd_en_2=1 with rd_addr_2=8'h15 in cycle 1; ocid_2=4'b1000 in cycle 2.
REQ-031 Conflict: requestors 1, 4 and 6 on bank 0 with ptr_0=0 held for 3 cycles -> grant order 1, 4, 6; ocid_0 = 4'b1001, 4'b1100, 4'b1110 in consecutive cycles.
REQ-032 Parallel: requestors 0/3/5/7 on banks 0/1/2/3 -> four grants in the same cycle; all four ocid_k valid two cycles later.
REQ-033 Writeback block: RF_WR_1=1 for 2 cycles with requestor 2 on bank 1 -> no grant for 2 cycles; grant in cycle 3; ocid_1=4'b1010 in cycle 5.
REQ-034 Wrap: ptr_3=7, requestors 7 and 0 on bank 3 -> grant 7 first, then 0; ptr_3 ends at 1.
REQ-035 Reset mid-flight: assert rst one cycle after a grant -> all rd_en and ocid outputs 0; no valid tag appears after release.
